// File: rtl/vec_mem_port.sv
// Memory-stage access unit: splits a latched 128-bit load/store into 32-bit beats
// on a word-wide data memory, and returns the reassembled load with its destination.
module vec_mem_port #(
    parameter int ADDR_W = 16,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              rmem,
    input  logic              wmem,
    input  logic              VF,
    input  logic [ADDR_W-1:0] addr,
    input  logic [127:0]      wdata,
    input  logic [3:0]        rdest,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [127:0]      ld_data,
    output logic [3:0]        ld_dest,
    output logic              ld_valid
);

    localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

    state_t                  state_q;
    logic [LANE_W-1:0]       lane_q;
    logic [LANE_W-1:0]       lane_d;
    logic [LANE_W-1:0]       last_lane;
    logic                    vec_q;
    logic [3:0]              dest_q;
    logic [BEATS-1:0][31:0]  wdata_q;
    logic [BEATS-2:0][31:0]  rbuf_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic                    mem_we_q;
    logic                    mem_re_q;
    logic [31:0]             mem_wdata_q;
    logic [127:0]            ld_data_q;
    logic [3:0]              ld_dest_q;
    logic                    ld_valid_q;

    assign lane_d    = lane_q + 1'b1;
    assign last_lane = vec_q ? LANE_W'(BEATS - 1) : '0;

    // Early load beats land in rbuf_q so an aborted load leaves ld_data untouched.
    // NOTE: every register here uses <= so all updates see pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            vec_q       <= 1'b0;
            dest_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            ld_data_q   <= '0;
            ld_dest_q   <= '0;
            ld_valid_q  <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!flush && (rmem || wmem)) begin
                        mem_addr_q <= addr;
                        wdata_q    <= wdata;
                        dest_q     <= rdest;
                        vec_q      <= VF;
                        lane_q     <= '0;
                        if (wmem) begin
                            state_q     <= WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= wdata[31:0];
                        end else begin
                            state_q  <= RD;
                            mem_re_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (lane_q == last_lane) begin
                        state_q  <= IDLE;
                        mem_we_q <= 1'b0;
                    end else begin
                        lane_q      <= lane_d;
                        mem_addr_q  <= mem_addr_q + 1'b1;
                        mem_wdata_q <= wdata_q[lane_d];
                    end
                end
                RD: begin
                    if (flush) begin
                        state_q  <= IDLE;
                        mem_re_q <= 1'b0;
                    end else begin
                        if (lane_q != '0) begin
                            rbuf_q[lane_q - 1'b1] <= mem_rdata;
                        end
                        if (lane_q == last_lane) begin
                            state_q  <= FIN;
                            mem_re_q <= 1'b0;
                        end else begin
                            lane_q     <= lane_d;
                            mem_addr_q <= mem_addr_q + 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    if (!flush) begin
                        ld_data_q  <= vec_q ? {mem_rdata, rbuf_q}
                                            : {{(32 * (BEATS - 1)){1'b0}}, mem_rdata};
                        ld_dest_q  <= dest_q;
                        ld_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_wdata = mem_wdata_q;
    assign ld_data   = ld_data_q;
    assign ld_dest   = ld_dest_q;
    assign ld_valid  = ld_valid_q;

endmodule
